// File: rtl/lpf_multi.sv
// Multi-channel hysteresis low-pass filter: per-channel synchroniser, saturating
// up/down counter and shared runtime thresholds producing level plus edge pulses.
module lpf_multi #(
  parameter int CH   = 8,
  parameter int LEN  = 16,
  parameter int SYNC = 2,
  parameter int INIT = 0,
  localparam int CW  = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  input  logic          clr,
  input  logic [CW-1:0] thr_top,
  input  logic [CW-1:0] thr_bot,
  input  logic [CH-1:0] in,
  output logic [CH-1:0] out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          cfg_err
);

  localparam logic          INIT_BIT = (INIT != 0);
  localparam logic [CW-1:0] CNT_MAX  = CW'(LEN - 1);
  localparam logic [CW-1:0] CNT_RST  = INIT_BIT ? CNT_MAX : '0;

  if (LEN < 4) begin : g_len_err
    $error("lpf_multi: LEN must be >= 4");
  end
  if (CH < 1) begin : g_ch_err
    $error("lpf_multi: CH must be >= 1");
  end
  if (SYNC == 1) begin : g_sync_err
    $error("lpf_multi: SYNC must be 0 or >= 2");
  end

  logic [CH-1:0] s;

  // The synchroniser runs every clock regardless of ce and is untouched by clr.
  if (SYNC == 0) begin : g_nosync
    assign s = in;
  end else begin : g_sync
    logic [SYNC-1:0][CH-1:0] sync_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync_q <= {(SYNC*CH){INIT_BIT}};
      end else begin
        sync_q <= {sync_q[SYNC-2:0], in};
      end
    end
    assign s = sync_q[SYNC-1];
  end

  logic [CH-1:0][CW-1:0] cnt;
  logic                  cfg_bad;

  assign cfg_bad = (thr_bot >= thr_top) || (32'(thr_top) > 32'(LEN - 1));

  // Decisions look at the pre-update count, so out trails the crossing by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= {CH{CNT_RST}};
      out     <= {CH{INIT_BIT}};
      rise    <= '0;
      fall    <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_bad;
      for (int i = 0; i < CH; i++) begin
        if (clr) begin
          cnt[i]  <= CNT_RST;
          out[i]  <= INIT_BIT;
          rise[i] <= 1'b0;
          fall[i] <= 1'b0;
        end else begin
          rise[i] <= 1'b0;
          fall[i] <= 1'b0;
          if (!cfg_bad) begin
            if (out[i] && (cnt[i] <= thr_bot)) begin
              out[i]  <= 1'b0;
              fall[i] <= 1'b1;
            end else if (!out[i] && (cnt[i] >= thr_top)) begin
              out[i]  <= 1'b1;
              rise[i] <= 1'b1;
            end
          end
          if (ce) begin
            if (s[i] && (cnt[i] != CNT_MAX)) begin
              cnt[i] <= cnt[i] + 1'b1;
            end else if (!s[i] && (cnt[i] != '0)) begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_lpf_multi.sv
// Randomised and directed bench for lpf_multi, checked every cycle against an
// integer-count behavioural model of the filter.
module tb_lpf_multi;
  localparam int CH   = 8;
  localparam int LEN  = 16;
  localparam int SYNC = 2;
  localparam int INIT = 0;
  localparam int CW   = $clog2(LEN);

  logic          clk = 1'b0;
  logic          rst, ce, clr;
  logic [CW-1:0] thrTop, thrBot;
  logic [CH-1:0] inSig, outSig, riseSig, fallSig;
  logic          cfgErr;

  int vectors = 0;
  int miscompares = 0;

  int            mCnt [CH];
  logic [CH-1:0] mOut, mRise, mFall;
  logic          mCfg;
  logic [CH-1:0] mSh [SYNC];
  logic [CH-1:0] riseSeen;

  lpf_multi #(.CH(CH), .LEN(LEN), .SYNC(SYNC), .INIT(INIT)) dut (
    .clk(clk), .rst(rst), .ce(ce), .clr(clr),
    .thr_top(thrTop), .thr_bot(thrBot), .in(inSig),
    .out(outSig), .rise(riseSig), .fall(fallSig), .cfg_err(cfgErr)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    for (int i = 0; i < CH; i++) mCnt[i] = (INIT != 0) ? LEN - 1 : 0;
    mOut  = {CH{INIT != 0}};
    mRise = '0;
    mFall = '0;
    mCfg  = 1'b0;
    for (int k = 0; k < SYNC; k++) mSh[k] = {CH{INIT != 0}};
  endtask

  // Next state after the coming clock edge, from the inputs currently driven.
  task automatic modelStep();
    bit err;
    logic [CH-1:0] s;
    if (rst) begin
      modelReset();
    end else begin
      err = (thrBot >= thrTop) || (int'(thrTop) > LEN - 1);
      s = mSh[SYNC-1];
      for (int i = 0; i < CH; i++) begin
        mRise[i] = 1'b0;
        mFall[i] = 1'b0;
        if (clr) begin
          mCnt[i] = (INIT != 0) ? LEN - 1 : 0;
          mOut[i] = (INIT != 0);
        end else begin
          if (!err) begin
            if (mOut[i] && mCnt[i] <= int'(thrBot)) begin
              mOut[i] = 1'b0;
              mFall[i] = 1'b1;
            end else if (!mOut[i] && mCnt[i] >= int'(thrTop)) begin
              mOut[i] = 1'b1;
              mRise[i] = 1'b1;
            end
          end
          if (ce) begin
            if (s[i] && mCnt[i] < LEN - 1) mCnt[i] = mCnt[i] + 1;
            else if (!s[i] && mCnt[i] > 0) mCnt[i] = mCnt[i] - 1;
          end
        end
      end
      for (int k = SYNC - 1; k > 0; k--) mSh[k] = mSh[k-1];
      mSh[0] = inSig;
      mCfg = err;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check("out", 32'(outSig), 32'(mOut));
    check("rise", 32'(riseSig), 32'(mRise));
    check("fall", 32'(fallSig), 32'(mFall));
    check("cfg_err", 32'(cfgErr), 32'(mCfg));
    riseSeen |= riseSig;
  endtask

  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; clr = 1'b0;
    thrTop = 4'd12; thrBot = 4'd4; inSig = '0;
    riseSeen = '0;
    modelReset();
    @(negedge clk);
    checkOutput();
    check("reset_out", 32'(outSig), 32'h0);
    check("reset_cfg", 32'(cfgErr), 32'h0);
    applyStimulus();
    rst = 1'b0;

    $display("[TB] step response");
    inSig[0] = 1'b1;
    ce = 1'b1;
    for (int e = 1; e <= 14; e++) applyStimulus();
    check("step_out_e14", 32'(outSig[0]), 32'h0);
    applyStimulus();
    check("step_out_e15", 32'(outSig[0]), 32'h1);
    check("step_rise_e15", 32'(riseSig[0]), 32'h1);

    $display("[TB] clear while high");
    clr = 1'b1;
    applyStimulus();
    clr = 1'b0;
    check("clr_out", 32'(outSig[0]), 32'h0);
    check("clr_fall", 32'(fallSig[0]), 32'h0);
    check("clr_rise", 32'(riseSig[0]), 32'h0);

    for (int e = 0; e < 20; e++) applyStimulus();
    check("sat_out", 32'(outSig[0]), 32'h1);

    $display("[TB] fall from saturation");
    inSig[0] = 1'b0;
    for (int e = 1; e <= 13; e++) applyStimulus();
    check("fall_out_e13", 32'(outSig[0]), 32'h1);
    applyStimulus();
    check("fall_out_e14", 32'(outSig[0]), 32'h0);
    check("fall_pulse_e14", 32'(fallSig[0]), 32'h1);
    for (int e = 0; e < 20; e++) applyStimulus();

    $display("[TB] glitch rejection");
    riseSeen = '0;
    inSig[3] = 1'b1;
    for (int e = 0; e < 10; e++) applyStimulus();
    inSig[3] = 1'b0;
    for (int e = 0; e < 20; e++) applyStimulus();
    check("glitch_out", 32'(outSig[3]), 32'h0);
    check("glitch_rise", 32'(riseSeen), 32'h0);

    $display("[TB] configuration error");
    thrBot = 4'd10; thrTop = 4'd8;
    applyStimulus();
    check("cfg_err_set", 32'(cfgErr), 32'h1);
    for (int e = 0; e < 40; e++) begin
      inSig[0] = (e % 20) < 10;
      applyStimulus();
    end
    thrTop = 4'd12; thrBot = 4'd4;
    applyStimulus();
    check("cfg_err_clear", 32'(cfgErr), 32'h0);
    for (int e = 0; e < 20; e++) applyStimulus();

    $display("[TB] time base");
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    inSig = 8'h02;
    for (int k = 1; k <= 49; k++) begin
      ce = (k % 4 == 0);
      applyStimulus();
      if (k == 48) check("tb_out_e48", 32'(outSig[1]), 32'h0);
      if (k == 49) begin
        check("tb_out_e49", 32'(outSig[1]), 32'h1);
        check("tb_rise_e49", 32'(riseSig[1]), 32'h1);
      end
    end

    $display("[TB] asynchronous reset");
    #2 rst = 1'b1;
    #1 check("async_out", 32'(outSig), 32'h0);
    modelReset();
    applyStimulus();
    rst = 1'b0;
    ce = 1'b0;
    for (int e = 0; e < 5; e++) applyStimulus();

    $display("[TB] random stimulus");
    ce = 1'b1;
    for (int e = 0; e < 4000; e++) begin
      for (int i = 0; i < CH; i++) if ($urandom_range(0, 15) == 0) inSig[i] = ~inSig[i];
      ce  = $urandom_range(0, 1) == 1;
      clr = $urandom_range(0, 199) == 0;
      rst = $urandom_range(0, 499) == 0;
      if ($urandom_range(0, 49) == 0) begin
        thrTop = CW'($urandom_range(0, LEN - 1));
        thrBot = CW'($urandom_range(0, LEN - 1));
      end else if ($urandom_range(0, 99) == 0) begin
        thrTop = 4'd12;
        thrBot = 4'd4;
      end
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lpf_multi.md
Name: lpf_multi

Overview:
- Multi-channel hysteresis low-pass filter (debouncer/glitch suppressor) for slow 1-bit inputs: buttons, opto inputs, comparator outputs.
- Each of CH channels has a synchroniser, a saturating up/down counter and runtime-programmable hysteresis thresholds.
- Each channel produces a filtered level plus single-cycle rise and fall event pulses.
- A sample strobe sets the filter time base, so long debounce windows need no wide counters.

Parameters:
- CH, 8: number of independent channels.
- LEN, 16: counter span; count saturates at LEN-1. Must be >= 4.
- SYNC, 2: input synchroniser depth. 0 means no synchroniser; otherwise must be >= 2.
- INIT, 0: reset/clear level of out, and sets the counter reset value.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- ce  in  1  sample strobe; counters step only on cycles with ce=1.
- clr  in  1  synchronous clear of all channels to the INIT state.
- thr_top  in  CW  rise threshold, shared by all channels. CW = $clog2(LEN).
- thr_bot  in  CW  fall threshold, shared by all channels.
- in  in  CH  raw asynchronous inputs.
- out  out  CH  filtered levels.
- rise  out  CH  one-clk pulse when out goes 0->1.
- fall  out  CH  one-clk pulse when out goes 1->0.
- cfg_err  out  1  registered flag, high while thr_bot >= thr_top or thr_top > LEN-1.

Behaviour:
- Reset (rst high, asynchronous):
  - synchroniser flops = INIT;
  - cnt = 0 if INIT=0, else LEN-1;
  - out = INIT; rise = 0; fall = 0; cfg_err = 0.
- Synchroniser: SYNC-stage flop chain per channel, clocked every clk, independent of ce. s[i] is the last stage, or in[i] directly when SYNC=0.
- Counter, per channel, CW bits, updated only when ce=1:
  - s=1 and cnt != LEN-1: cnt+1.
  - s=0 and cnt != 0: cnt-1.
  - otherwise hold; no wrap-around in either direction.
  - ce=0: hold.
- Output decision, evaluated every clk against the registered (pre-update) cnt:
  - out=1 and cnt <= thr_bot: out becomes 0; fall pulses 1 in the same registered cycle.
  - out=0 and cnt >= thr_top: out becomes 1; rise pulses 1.
  - otherwise out holds; rise and fall are 0.
- Consequences of the output decision:
  - out lags the threshold crossing of cnt by exactly one clk.
  - rise and fall are never high together and never high for two consecutive clks on the same channel.
- Configuration error:
  - cfg_err is registered each clk from the threshold check.
  - While the check is true (combinational, same cycle), out, rise and fall on all channels freeze at hold/0.
  - Counters keep running during the error.
  - Once the thresholds are legal, decisions resume from the current cnt on the next clk.
- Thresholds are used live, with no shadow register. A threshold change takes effect on the next decision cycle.
- clr (synchronous):
  - cnt, out, rise, fall go to their reset values on the next edge.
  - Synchroniser flops are not cleared.
  - clr has priority over ce and over the threshold decision.
  - clr produces no rise/fall pulse even if out changes.
- Simultaneous ce and a decision in the same cycle: the decision uses the old cnt and the counter steps.
- Reset mid-operation: all state returns to reset values immediately; no pulse is emitted on reset deassert.
- Channels are fully independent; no cross-channel arbitration.
- Elaboration-time $error for LEN < 4, CH < 1, or SYNC == 1.

Test Plan:
- Step response: LEN=16, SYNC=2, INIT=0, thr_top=12, thr_bot=4, ce=1, in[0]=1 before edge 1.
  - cnt=1 after edge 3, cnt=12 after edge 14.
  - out[0]=1 and rise[0]=1 after edge 15; rise[0]=0 after edge 16.
  - cnt saturates at 15.
- Fall from saturation: cnt=15, out=1, in[0]=0.
  - cnt=4 after 11 steps (plus 2 clk synchroniser delay).
  - out[0]=0 with fall[0]=1 one clk later; cnt stops at 0.
- Glitch rejection: out=0, in[3] high for 10 clks then low; ce=1.
  - cnt peaks at 10, below 12, so out[3] stays 0.
  - No rise pulse; the other channels are unaffected.
- Time base: ce high 1 clk in 4, in[1]=1.
  - out[1] rises after 12 ce strobes, i.e. about 48 clks.
  - Counter is constant between strobes.
- Config error: set thr_bot=10, thr_top=8 while in toggles.
  - cfg_err=1 one clk later; out and pulses frozen.
  - Restore thr_top=12, thr_bot=4: cfg_err=0 and decisions resume.
- clr and reset: assert clr while cnt=13 and out=1 (INIT=0).
  - Next edge: cnt=0, out=0, no fall pulse.
  - Assert rst asynchronously mid-count: out=0 immediately; no pulse after release.
